// File: rtl/ym_write_sched.sv
// ym_write_sched: queues host register writes and replays them to the jt12 array on cen, paced per chip
// Ports:
//   clk_jt, rst (sync, active-high), cen (one-cycle clock enable)
//   host_cs/host_addr/host_din/host_wr_n : host write bus, a write is the falling edge of host_wr_n
//   ym_cs/ym_addr/ym_din/ym_wr_n         : shared bus to the YM instances, ym_cs=0 selects none
//   fifo_level/fifo_full/overflow/ready  : queue status, overflow is sticky until reset
module ym_write_sched #(
  parameter int YM_COUNT   = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WAIT  = 2,
  parameter int DATA_WAIT  = 14,
  parameter int STROBE_CEN = 2
) (
  input  logic                         clk_jt,
  input  logic                         rst,
  input  logic                         cen,
  input  logic [4:0]                   host_cs,
  input  logic [1:0]                   host_addr,
  input  logic [7:0]                   host_din,
  input  logic                         host_wr_n,
  output logic [4:0]                   ym_cs,
  output logic [1:0]                   ym_addr,
  output logic [7:0]                   ym_din,
  output logic                         ym_wr_n,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         fifo_full,
  output logic                         overflow,
  output logic                         ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, state_nx;
  logic wr_n_q, push, pop, load, head_busy;
  logic [14:0] mem [FIFO_DEPTH];
  logic [14:0] head;
  logic [AW-1:0] wp, rp;
  logic [7:0] cnt [YM_COUNT];
  logic [YM_COUNT-1:0] busy, hsel, osel;
  logic [7:0] scnt, scnt_nx;
  logic [4:0] o_cs;
  logic [1:0] o_addr;
  logic [7:0] o_din;
  assign push = wr_n_q && !host_wr_n && host_cs != 5'd0 && host_cs <= 5'(YM_COUNT);
  assign head = mem[rp];
  assign fifo_full = fifo_level == LW'(FIFO_DEPTH);
  assign head_busy = |(busy & hsel);
  assign ym_cs = state == IDLE ? 5'd0 : o_cs;
  assign ym_addr = o_addr;
  assign ym_din = o_din;
  assign ym_wr_n = state != STROBE;
  always_comb begin
    busy = '0;
    hsel = '0;
    osel = '0;
    for (int i = 0; i < YM_COUNT; i++) begin
      busy[i] = cnt[i] != 8'd0;
      hsel[i] = head[14:10] == 5'(i + 1);
      osel[i] = o_cs == 5'(i + 1);
    end
  end
  always_comb begin
    state_nx = state;
    scnt_nx = scnt;
    pop = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (fifo_level != '0 && !head_busy) begin
        pop = 1'b1;
        state_nx = SETUP;
      end
      SETUP: if (cen) begin
        scnt_nx = 8'd0;
        state_nx = STROBE;
      end
      STROBE: if (cen) begin
        load = scnt == 8'(STROBE_CEN - 1);
        scnt_nx = scnt + 8'd1;
        state_nx = load ? HOLD : STROBE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // a load on the final strobe cen overrides that cen's decrement
  always_ff @(posedge clk_jt)
    for (int i = 0; i < YM_COUNT; i++)
      if (rst) cnt[i] <= 8'd0;
      else if (load && osel[i]) cnt[i] <= o_addr[0] ? 8'(DATA_WAIT) : 8'(ADDR_WAIT);
      else if (cen && busy[i]) cnt[i] <= cnt[i] - 8'd1;
  always_ff @(posedge clk_jt)
    if (push && !fifo_full) mem[wp] <= {host_cs, host_addr, host_din};
  always_ff @(posedge clk_jt)
    if (rst) begin
      state <= IDLE;
      scnt <= 8'd0;
      wr_n_q <= 1'b1;
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
      ready <= 1'b1;
      o_cs <= 5'd0;
      o_addr <= 2'd0;
      o_din <= 8'd0;
    end else begin
      state <= state_nx;
      scnt <= scnt_nx;
      wr_n_q <= host_wr_n;
      wp <= wp + AW'(push && !fifo_full);
      rp <= rp + AW'(pop);
      fifo_level <= fifo_level + LW'(push && !fifo_full) - LW'(pop);
      overflow <= overflow || (push && fifo_full);
      ready <= fifo_level == '0 && state == IDLE && busy == '0;
      if (pop) {o_cs, o_addr, o_din} <= head;
    end
endmodule

// File: tb/tb_ym_write_sched.sv
// tb_ym_write_sched: directed checks of queueing, strobe shape, per-chip pacing, overflow and reset
module tb_ym_write_sched;
  logic clk_jt = 1'b0, rst = 1'b1, cen;
  logic [4:0] host_cs = 5'd0;
  logic [1:0] host_addr = 2'd0;
  logic [7:0] host_din = 8'd0;
  logic host_wr_n = 1'b1;
  logic [4:0] ym_cs;
  logic [1:0] ym_addr;
  logic [7:0] ym_din;
  logic ym_wr_n, fifo_full, overflow, ready;
  logic [4:0] fifo_level;
  int cc = 0, ncen = 0, total = 0, bad = 0;
  ym_write_sched dut (
    .clk_jt(clk_jt), .rst(rst), .cen(cen),
    .host_cs(host_cs), .host_addr(host_addr), .host_din(host_din), .host_wr_n(host_wr_n),
    .ym_cs(ym_cs), .ym_addr(ym_addr), .ym_din(ym_din), .ym_wr_n(ym_wr_n),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .overflow(overflow), .ready(ready)
  );
  always #5 clk_jt = ~clk_jt;
  assign cen = cc == 5;
  always @(posedge clk_jt) begin
    cc <= cc == 5 ? 0 : cc + 1;
    if (cen) ncen <= ncen + 1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int cs, input int a, input int d);
    @(negedge clk_jt);
    host_cs = 5'(cs);
    host_addr = 2'(a);
    host_din = 8'(d);
    host_wr_n = 1'b0;
    @(negedge clk_jt);
    host_wr_n = 1'b1;
  endtask
  // returns at the first negedge with ym_wr_n high again (the HOLD cycle); lat=-1 on timeout
  task automatic wait_strobe(input int bound, output int lat, output int len, output int cs,
                             output int a, output int d, output int c0, output int c1);
    lat = -1; len = 0; cs = 0; a = 0; d = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_jt);
      if (!ym_wr_n) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    cs = ym_cs; a = ym_addr; d = ym_din; c0 = ncen;
    while (!ym_wr_n && len < 100) begin
      len++;
      @(negedge clk_jt);
    end
    c1 = ncen;
  endtask
  task automatic wait_ready(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_jt);
      if (ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask
  int lat, len, cs, a, d, c0, c1, p1, n;
  initial begin
    repeat (3) @(negedge clk_jt);
    rst = 1'b0;
    @(negedge clk_jt);
    chk("rst_cs", ym_cs, 0);
    chk("rst_addr", ym_addr, 0);
    chk("rst_din", ym_din, 0);
    chk("rst_wr_n", ym_wr_n, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", ready, 1);
    wr(3, 1, 8'h5A);
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    chk("single_lat_ok", int'(lat >= 1 && lat <= 6), 1);
    chk("single_cs", cs, 3);
    chk("single_addr", a, 1);
    chk("single_din", d, 8'h5A);
    chk("single_len", len, 12);
    chk("single_cens", c1 - c0, 2);
    chk("hold_cs", ym_cs, 3);
    chk("hold_ready", ready, 0);
    @(negedge clk_jt);
    chk("idle_cs", ym_cs, 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      if (cen) n++;
      @(negedge clk_jt);
    end
    chk("single_busy_cens", n, 14);
    wait_ready(300);
    wr(1, 0, 8'h2B);
    wr(1, 1, 8'h10);
    wr(1, 1, 8'h20);
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    chk("pace1_addr", a, 0);
    p1 = c1;
    wait_strobe(200, lat, len, cs, a, d, c0, c1);
    chk("pace2_din", d, 8'h10);
    chk("pace2_gap", c0 - p1, 3);
    p1 = c1;
    wait_strobe(200, lat, len, cs, a, d, c0, c1);
    chk("pace3_din", d, 8'h20);
    chk("pace3_gap", c0 - p1, 15);
    wait_ready(300);
    wr(1, 1, 8'h31);
    wr(2, 1, 8'h32);
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    chk("ilv1_cs", cs, 1);
    p1 = c1;
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    chk("ilv2_cs", cs, 2);
    chk("ilv2_gap", c0 - p1, 1);
    chk("ilv2_ready", ready, 0);
    wait_ready(300);
    wr(0, 1, 8'h41);
    wr(10, 1, 8'h42);
    @(negedge clk_jt);
    chk("oor_level", fifo_level, 0);
    chk("oor_ovf", overflow, 0);
    wait_strobe(20, lat, len, cs, a, d, c0, c1);
    chk("oor_nostrobe", lat, -1);
    wait_ready(300);
    wr(5, 1, 8'hEE);
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    for (int k = 1; k <= 17; k++) wr(5, 1, k);
    @(negedge clk_jt);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", overflow, 1);
    for (int k = 1; k <= 16; k++) begin
      wait_strobe(200, lat, len, cs, a, d, c0, c1);
      chk($sformatf("ovf_din%0d", k), d, k);
    end
    wait_strobe(200, lat, len, cs, a, d, c0, c1);
    chk("ovf_no17", lat, -1);
    chk("ovf_drained", fifo_level, 0);
    chk("ovf_sticky", overflow, 1);
    wait_ready(300);
    wr(2, 1, 8'h11);
    wr(2, 1, 8'h22);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_jt);
      if (!ym_wr_n) break;
      n++;
    end
    chk("rs_in_strobe", ym_wr_n, 0);
    chk("rs_level_pre", fifo_level, 1);
    rst = 1'b1;
    @(negedge clk_jt);
    chk("rs_wr_n", ym_wr_n, 1);
    chk("rs_cs", ym_cs, 0);
    chk("rs_level", fifo_level, 0);
    chk("rs_ovf", overflow, 0);
    rst = 1'b0;
    wr(4, 1, 8'hC3);
    wait_strobe(30, lat, len, cs, a, d, c0, c1);
    chk("post_cs", cs, 4);
    chk("post_din", d, 8'hC3);
    chk("post_len", len, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
